// File: rtl/sram_rmw_wrapper.sv
// sram_rmw_wrapper: multi-port word array with byte enables, natively or by read-modify-write
module sram_rmw_wrapper #(
    parameter int unsigned NumWords    = 32'd1024,
    parameter int unsigned DataWidth   = 32'd128,
    parameter int unsigned ByteWidth   = 32'd8,
    parameter int unsigned NumPorts    = 32'd2,
    parameter bit          BYTE_ACCESS = 1'b1,
    localparam int unsigned AddrWidth  = NumWords > 1 ? $clog2(NumWords) : 1,
    localparam int unsigned BeWidth    = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumPorts-1:0]            req_i,
    input  logic [NumPorts-1:0]            we_i,
    input  logic [NumPorts*AddrWidth-1:0]  addr_i,
    input  logic [NumPorts*DataWidth-1:0]  wdata_i,
    input  logic [NumPorts*BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]            gnt_o,
    output logic [NumPorts-1:0]            rvalid_o,
    output logic [NumPorts*DataWidth-1:0]  rdata_o
);
    typedef enum logic {IDLE, RMW_WR} state_t;
    logic [DataWidth-1:0] r_mem [NumWords];
    state_t               r_state [NumPorts];
    state_t               w_state_nx [NumPorts];
    logic [AddrWidth-1:0] r_addr [NumPorts];
    logic [DataWidth-1:0] r_wdata [NumPorts];
    logic [DataWidth-1:0] r_mask [NumPorts];
    logic [DataWidth-1:0] r_old [NumPorts];
    logic [NumPorts-1:0]  r_rvalid;
    logic [NumPorts*DataWidth-1:0] r_rdata;
    logic [AddrWidth-1:0] w_addr [NumPorts];
    logic [DataWidth-1:0] w_wdata [NumPorts];
    logic [DataWidth-1:0] w_mask [NumPorts];
    logic [DataWidth-1:0] w_rd [NumPorts];
    logic [DataWidth-1:0] w_fwd [NumPorts];
    logic [DataWidth-1:0] w_post [NumPorts];
    logic [BeWidth-1:0]   w_be [NumPorts];
    logic [NumPorts-1:0]  w_in_range, w_acc, w_commit, w_rmw_start, w_rmw_busy;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    // Unpack ports, classify each accepted request and expand byte enables to bit masks
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_addr[p]  = addr_i[p*AddrWidth +: AddrWidth];
            w_wdata[p] = wdata_i[p*DataWidth +: DataWidth];
            w_be[p]    = be_i[p*BeWidth +: BeWidth];
            for (int b = 0; b < DataWidth; b++) w_mask[p][b] = w_be[p][b / ByteWidth];
            w_in_range[p]  = 32'(w_addr[p]) < NumWords;
            w_rd[p]        = w_in_range[p] ? r_mem[w_addr[p]] : '0;
            w_acc[p]       = req_i[p] && gnt_o[p];
            w_commit[p]    = w_acc[p] && we_i[p] && |w_be[p] && (BYTE_ACCESS || &w_be[p]);
            w_rmw_start[p] = w_acc[p] && we_i[p] && |w_be[p] && !BYTE_ACCESS && !(&w_be[p]);
        end
    end
    // Per-port word views: w_fwd holds lower-index commits only, w_post all commits with lower index winning each lane
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            w_fwd[p]  = w_rd[p];
            w_post[p] = w_rd[p];
            for (int q = NumPorts - 1; q >= 0; q--) begin
                if (w_commit[q] && w_addr[q] == w_addr[p]) begin
                    w_post[p] = (w_post[p] & ~w_mask[q]) | (w_wdata[q] & w_mask[q]);
                    if (q < p) w_fwd[p] = (w_fwd[p] & ~w_mask[q]) | (w_wdata[q] & w_mask[q]);
                end
            end
        end
    end
    // RMW state register; reset abandons any pending merge
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) r_state[p] <= rst_i ? IDLE : w_state_nx[p];
    end
    // Next state: a partial write spends exactly one cycle in RMW_WR
    always_comb begin
        for (int p = 0; p < NumPorts; p++) w_state_nx[p] = (r_state[p] == IDLE && w_rmw_start[p]) ? RMW_WR : IDLE;
    end
    // Outputs: any merge in flight reserves the write slot and blocks every port
    always_comb begin
        for (int p = 0; p < NumPorts; p++) w_rmw_busy[p] = r_state[p] == RMW_WR;
        gnt_o = (rst_i || |w_rmw_busy) ? '0 : '1;
    end
    // Capture a partial write together with the forwarded old word
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (w_rmw_start[p]) begin
                r_addr[p]  <= w_addr[p];
                r_wdata[p] <= w_wdata[p];
                r_mask[p]  <= w_mask[p];
                r_old[p]   <= w_fwd[p];
            end
        end
    end
    // Array writes: native commits store the fully resolved word, merges store full words with lower index last
    always_ff @(posedge clk_i) begin
        for (int p = NumPorts - 1; p >= 0; p--) begin
            if (w_commit[p] && w_in_range[p]) r_mem[w_addr[p]] <= w_post[p];
            if (w_rmw_busy[p] && !rst_i && 32'(r_addr[p]) < NumWords)
                r_mem[r_addr[p]] <= (r_old[p] & ~r_mask[p]) | (r_wdata[p] & r_mask[p]);
        end
    end
    // Read data returns one cycle after accept, read-first, holding between reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                r_rvalid[p] <= w_acc[p] && !we_i[p];
                if (w_acc[p] && !we_i[p]) r_rdata[p*DataWidth +: DataWidth] <= w_rd[p];
            end
        end
    end
endmodule

// File: tb/tb_sram_rmw_wrapper.sv
// tb_sram_rmw_wrapper: drives a native-byte and an RMW instance in lockstep against a word-level model
module tb_sram_rmw_wrapper;
    localparam int N = 16;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req = '0, we = '0;
    logic [7:0]  addr = '0, be = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  gnt [2];
    logic [1:0]  rvalid [2];
    logic [63:0] rdata [2];
    int          n_tests = 0, n_fail = 0;
    logic [31:0] m_mem [2][N];
    bit          m_pend [2][2];
    logic [3:0]  m_pa [2][2];
    logic [31:0] m_pd [2][2], m_pm [2][2], m_po [2][2];
    logic [1:0]  m_rvalid [2];
    logic [63:0] m_rdata [2];

    sram_rmw_wrapper #(.NumWords(16), .DataWidth(32), .ByteWidth(8), .NumPorts(2), .BYTE_ACCESS(1'b1)) u_ba (
        .clk_i(clk), .rst_i(rst_i), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]));
    sram_rmw_wrapper #(.NumWords(16), .DataWidth(32), .ByteWidth(8), .NumPorts(2), .BYTE_ACCESS(1'b0)) u_rmw (
        .clk_i(clk), .rst_i(rst_i), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] b);
        logic [31:0] m;
        for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{b[l]}};
        return m;
    endfunction

    // Word-level model of one instance: i=0 native byte writes, i=1 partial writes via RMW
    task automatic model_step(input int i);
        logic [31:0] snap [N];
        bit          claimed [N][4];
        logic [3:0]  a, b;
        logic [31:0] d;
        if (rst_i) begin
            m_pend[i][0] = 0; m_pend[i][1] = 0;
            m_rvalid[i] = '0; m_rdata[i] = '0;
            return;
        end
        m_rvalid[i] = '0;
        if (m_pend[i][0] || m_pend[i][1]) begin
            for (int p = 1; p >= 0; p--)
                if (m_pend[i][p]) m_mem[i][m_pa[i][p]] = (m_po[i][p] & ~m_pm[i][p]) | (m_pd[i][p] & m_pm[i][p]);
            m_pend[i][0] = 0; m_pend[i][1] = 0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            snap[k] = m_mem[i][k];
            for (int l = 0; l < 4; l++) claimed[k][l] = 0;
        end
        for (int p = 0; p < 2; p++) begin
            if (!req[p]) continue;
            a = addr[4*p +: 4]; b = be[4*p +: 4]; d = wdata[32*p +: 32];
            if (!we[p]) begin
                m_rvalid[i][p] = 1'b1;
                m_rdata[i][32*p +: 32] = snap[a];
            end else if (b != 0) begin
                if (i == 0 || b == 4'hF) begin
                    for (int l = 0; l < 4; l++)
                        if (b[l] && !claimed[a][l]) begin
                            m_mem[i][a][8*l +: 8] = d[8*l +: 8];
                            claimed[a][l] = 1;
                        end
                end else begin
                    m_pend[i][p] = 1; m_pa[i][p] = a; m_pd[i][p] = d;
                    m_pm[i][p] = lanes(b); m_po[i][p] = m_mem[i][a];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("gnt%0d", i), 64'(gnt[i]), (rst_i || m_pend[i][0] || m_pend[i][1]) ? 64'd0 : 64'd3);
            chk($sformatf("rvalid%0d", i), 64'(rvalid[i]), 64'(m_rvalid[i]));
            chk($sformatf("rdata%0d", i), rdata[i], m_rdata[i]);
        end
    end

    task automatic op(input logic [1:0] rq, input logic [1:0] wr, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] b0, input logic [3:0] b1);
        req = rq; we = wr; addr = {a1, a0}; wdata = {d1, d0}; be = {b1, b0};
        @(posedge clk); #2;
    endtask

    task automatic idle();
        op(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt_ba", 64'(gnt[0]), 64'd0);
        chk("rst_gnt_rmw", 64'(gnt[1]), 64'd0);
        chk("rst_rvalid_rmw", 64'(rvalid[1]), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("gnt_after_rst", {gnt[1], gnt[0]}, 64'hF);
        op(2'b01, 2'b01, 4'd3, 4'd0, 32'hAABBCCDD, 32'd0, 4'hF, 4'h0);
        op(2'b01, 2'b00, 4'd3, 4'd0, 32'd0, 32'd0, 4'h0, 4'h0);
        chk("wr_rd_rvalid_ba", 64'(rvalid[0]), 64'd1);
        chk("wr_rd_data_ba", 64'(rdata[0][31:0]), 64'hAABBCCDD);
        chk("wr_rd_data_rmw", 64'(rdata[1][31:0]), 64'hAABBCCDD);
        op(2'b01, 2'b01, 4'd5, 4'd0, 32'h11223344, 32'd0, 4'hF, 4'h0);
        op(2'b01, 2'b01, 4'd5, 4'd0, 32'h000000FF, 32'd0, 4'h1, 4'h0);
        chk("rmw_gnt_blocked", 64'(gnt[1]), 64'd0);
        chk("ba_gnt_free", 64'(gnt[0]), 64'd3);
        idle();
        chk("rmw_gnt_back", 64'(gnt[1]), 64'd3);
        op(2'b01, 2'b00, 4'd5, 4'd0, 32'd0, 32'd0, 4'h0, 4'h0);
        chk("rmw_merge_rmw", 64'(rdata[1][31:0]), 64'h112233FF);
        chk("rmw_merge_ba", 64'(rdata[0][31:0]), 64'h112233FF);
        op(2'b11, 2'b11, 4'd7, 4'd7, 32'h1, 32'h2, 4'hF, 4'hF);
        op(2'b10, 2'b00, 4'd0, 4'd7, 32'd0, 32'd0, 4'h0, 4'h0);
        chk("same_addr_ba", 64'(rdata[0][63:32]), 64'h1);
        chk("same_addr_rmw", 64'(rdata[1][63:32]), 64'h1);
        op(2'b01, 2'b01, 4'd2, 4'd0, 32'h9, 32'd0, 4'hF, 4'h0);
        op(2'b11, 2'b01, 4'd2, 4'd2, 32'h5, 32'd0, 4'hF, 4'h0);
        chk("read_first_ba", 64'(rdata[0][63:32]), 64'h9);
        chk("read_first_rmw", 64'(rdata[1][63:32]), 64'h9);
        op(2'b10, 2'b00, 4'd0, 4'd2, 32'd0, 32'd0, 4'h0, 4'h0);
        chk("read_after_ba", 64'(rdata[0][63:32]), 64'h5);
        op(2'b01, 2'b01, 4'd8, 4'd0, 32'd0, 32'd0, 4'hF, 4'h0);
        op(2'b11, 2'b11, 4'd8, 4'd8, 32'h0000AAAA, 32'hBBBBBBBB, 4'h3, 4'hF);
        idle();
        op(2'b01, 2'b00, 4'd8, 4'd0, 32'd0, 32'd0, 4'h0, 4'h0);
        chk("lane_prio_ba", 64'(rdata[0][31:0]), 64'hBBBBAAAA);
        chk("lane_prio_rmw", 64'(rdata[1][31:0]), 64'h0000AAAA);
        op(2'b01, 2'b01, 4'd3, 4'd0, 32'h12345678, 32'd0, 4'h0, 4'h0);
        chk("be0_no_rmw", 64'(gnt[1]), 64'd3);
        op(2'b01, 2'b00, 4'd3, 4'd0, 32'd0, 32'd0, 4'h0, 4'h0);
        chk("be0_noop_rmw", 64'(rdata[1][31:0]), 64'hAABBCCDD);
        op(2'b01, 2'b01, 4'd5, 4'd0, 32'hEEEEEEEE, 32'd0, 4'h2, 4'h0);
        rst_i = 1'b1;
        idle();
        chk("rst_gnt", {gnt[1], gnt[0]}, 64'd0);
        chk("rst_rvalid", {rvalid[1], rvalid[0]}, 64'd0);
        chk("rst_rdata_rmw", rdata[1], 64'd0);
        rst_i = 1'b0;
        op(2'b01, 2'b00, 4'd5, 4'd0, 32'd0, 32'd0, 4'h0, 4'h0);
        chk("rst_abandon_rmw", 64'(rdata[1][31:0]), 64'h112233FF);
        chk("native_ba", 64'(rdata[0][31:0]), 64'h1122EEFF);
        idle();
        chk("hold_rvalid", 64'(rvalid[1]), 64'd0);
        chk("hold_rdata", 64'(rdata[1][31:0]), 64'h112233FF);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
